// File: rtl/apb_txrx_slave.sv
// ============================================================================
// apb_txrx_slave
// APB register slave bridging a CPU to Transmit/Receive blocks via two FIFOs.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module apb_txrx_slave #(
    parameter int DATA_W   = 8,
    parameter int TX_DEPTH = 4,
    parameter int RX_DEPTH = 4
) (
    input  logic              pclk,
    input  logic              npreset,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [3:0]        paddr,
    input  logic [DATA_W-1:0] pwdata,
    output logic [DATA_W-1:0] prdata,
    output logic              pready,
    output logic              pslverr,
    output logic              transmit,
    output logic [DATA_W-1:0] tx_data,
    input  logic              tx_done,
    input  logic              receive,
    input  logic [DATA_W-1:0] rx_data,
    output logic              rx_done,
    output logic              rx_interrupt,
    output logic              tx_interrupt
);

    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam int RX_AW = $clog2(RX_DEPTH);
    localparam logic [TX_AW:0] TX_PTR_ONE = 1;
    localparam logic [RX_AW:0] RX_PTR_ONE = 1;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_IRQ_EN = 2'd2;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_t;
    typedef enum logic       {TX_IDLE, TX_BUSY}    tx_state_t;

    apb_state_t apb_state_q, apb_state_d;
    tx_state_t  tx_state_q,  tx_state_d;

    logic [DATA_W-1:0] tx_mem [TX_DEPTH];
    logic [DATA_W-1:0] rx_mem [RX_DEPTH];
    logic [TX_AW:0]    tx_wptr_q, tx_rptr_q;
    logic [RX_AW:0]    rx_wptr_q, rx_rptr_q;

    logic              overrun_q;
    logic [1:0]        irq_en_q;
    logic [1:0]        addr_q;
    logic              write_q;
    logic [DATA_W-1:0] prdata_q, rdata_d;
    logic              pslverr_q, err_d;
    logic              pready_q;
    logic [DATA_W-1:0] tx_data_q;
    logic              rx_done_q, rx_irq_q, tx_irq_q;

    logic tx_empty, tx_full, rx_empty, rx_full;
    logic setup_done, xfer_ok;
    logic tx_push, tx_pop, rx_push, rx_pop, rx_drop;
    logic irq_wr, clr_wr;
    logic addr_unused;

    assign addr_unused = ^paddr[1:0];

    assign tx_empty = (tx_wptr_q == tx_rptr_q);
    assign tx_full  = (tx_wptr_q[TX_AW] != tx_rptr_q[TX_AW]) &&
                      (tx_wptr_q[TX_AW-1:0] == tx_rptr_q[TX_AW-1:0]);
    assign rx_empty = (rx_wptr_q == rx_rptr_q);
    assign rx_full  = (rx_wptr_q[RX_AW] != rx_rptr_q[RX_AW]) &&
                      (rx_wptr_q[RX_AW-1:0] == rx_rptr_q[RX_AW-1:0]);

    // Errors and read data are resolved on entry to ACCESS; side effects
    // are applied on the edge that closes the ACCESS cycle.
    assign setup_done = (apb_state_q == SETUP) && psel && penable;
    assign xfer_ok    = (apb_state_q == ACCESS) && !pslverr_q;
    assign tx_push    = xfer_ok &&  write_q && (addr_q == ADDR_DATA);
    assign rx_pop     = xfer_ok && !write_q && (addr_q == ADDR_DATA);
    assign irq_wr     = xfer_ok &&  write_q && (addr_q == ADDR_IRQ_EN);
    assign clr_wr     = xfer_ok &&  write_q && (addr_q == 2'd3) && pwdata[4];
    assign tx_pop     = (tx_state_q == TX_BUSY) && tx_done;
    // A pop in the same cycle frees the slot the incoming word needs.
    assign rx_push    = receive && (!rx_full || rx_pop);
    assign rx_drop    = receive && rx_full && !rx_pop;

    always_comb begin
        apb_state_d = apb_state_q;
        case (apb_state_q)
            IDLE:    if (psel && !penable) apb_state_d = SETUP;
            SETUP: begin
                if (!psel)        apb_state_d = IDLE;
                else if (penable) apb_state_d = ACCESS;
            end
            ACCESS:  apb_state_d = IDLE;
            default: apb_state_d = IDLE;
        endcase
    end

    always_comb begin
        err_d   = 1'b0;
        rdata_d = '0;
        case (paddr[3:2])
            ADDR_DATA: begin
                if (pwrite)        err_d = tx_full;
                else if (rx_empty) err_d = 1'b1;
                else               rdata_d = rx_mem[rx_rptr_q[RX_AW-1:0]];
            end
            ADDR_STATUS: begin
                if (pwrite) err_d = 1'b1;
                else        rdata_d[4:0] = {overrun_q, tx_full, tx_empty, rx_full, rx_empty};
            end
            ADDR_IRQ_EN: begin
                if (!pwrite) rdata_d[1:0] = irq_en_q;
            end
            default: begin
                if (!pwrite) err_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge pclk or negedge npreset) begin
        if (!npreset) begin
            apb_state_q <= IDLE;
            pready_q    <= 1'b0;
            pslverr_q   <= 1'b0;
            prdata_q    <= '0;
            addr_q      <= 2'd0;
            write_q     <= 1'b0;
        end else begin
            apb_state_q <= apb_state_d;
            pready_q    <= setup_done;
            pslverr_q   <= setup_done ? err_d : 1'b0;
            prdata_q    <= setup_done ? rdata_d : '0;
            if (setup_done) begin
                addr_q  <= paddr[3:2];
                write_q <= pwrite;
            end
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        case (tx_state_q)
            TX_IDLE: if (!tx_empty) tx_state_d = TX_BUSY;
            TX_BUSY: if (tx_done)   tx_state_d = TX_IDLE;
            default: tx_state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge npreset) begin
        if (!npreset) begin
            tx_state_q <= TX_IDLE;
            tx_data_q  <= '0;
        end else begin
            tx_state_q <= tx_state_d;
            if (tx_state_q == TX_IDLE && !tx_empty)
                tx_data_q <= tx_mem[tx_rptr_q[TX_AW-1:0]];
        end
    end

    always_ff @(posedge pclk or negedge npreset) begin
        if (!npreset) begin
            tx_wptr_q <= '0;
            tx_rptr_q <= '0;
            rx_wptr_q <= '0;
            rx_rptr_q <= '0;
            overrun_q <= 1'b0;
            irq_en_q  <= 2'b00;
            rx_done_q <= 1'b0;
            rx_irq_q  <= 1'b0;
            tx_irq_q  <= 1'b0;
        end else begin
            if (tx_push) tx_wptr_q <= tx_wptr_q + TX_PTR_ONE;
            if (tx_pop)  tx_rptr_q <= tx_rptr_q + TX_PTR_ONE;
            if (rx_push) rx_wptr_q <= rx_wptr_q + RX_PTR_ONE;
            if (rx_pop)  rx_rptr_q <= rx_rptr_q + RX_PTR_ONE;
            if (rx_drop)     overrun_q <= 1'b1;
            else if (clr_wr) overrun_q <= 1'b0;
            if (irq_wr) irq_en_q <= pwdata[1:0];
            rx_done_q <= rx_push;
            rx_irq_q  <= irq_en_q[0] & (!rx_empty | overrun_q);
            tx_irq_q  <= irq_en_q[1] & tx_empty;
        end
    end

    // FIFO storage carries no reset; emptiness is defined by the pointers.
    always_ff @(posedge pclk) begin
        if (tx_push) tx_mem[tx_wptr_q[TX_AW-1:0]] <= pwdata;
        if (rx_push) rx_mem[rx_wptr_q[RX_AW-1:0]] <= rx_data;
    end

    assign prdata       = prdata_q;
    assign pready       = pready_q;
    assign pslverr      = pslverr_q;
    assign transmit     = (tx_state_q == TX_BUSY);
    assign tx_data      = tx_data_q;
    assign rx_done      = rx_done_q;
    assign rx_interrupt = rx_irq_q;
    assign tx_interrupt = tx_irq_q;

endmodule

`default_nettype wire

// File: tb/tb_apb_txrx_slave.sv
// Directed bench for apb_txrx_slave with TX/RX scoreboards.
`timescale 1ns/1ps
`default_nettype none

module tb_apb_txrx_slave;

    localparam int DW = 8;

    logic          pclk = 1'b0;
    logic          npreset = 1'b0;
    logic          psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [3:0]    paddr = '0;
    logic [DW-1:0] pwdata = '0;
    logic [DW-1:0] prdata;
    logic          pready, pslverr, transmit;
    logic [DW-1:0] tx_data;
    logic          tx_done = 1'b0, receive = 1'b0;
    logic [DW-1:0] rx_data = '0;
    logic          rx_done, rx_interrupt, tx_interrupt;

    int n_chk = 0, n_pass = 0, n_fail = 0;
    logic [DW-1:0] tx_q[$];
    logic [DW-1:0] rx_q[$];
    logic [DW-1:0] rd, exp_w;
    logic          err;
    int            lat;

    apb_txrx_slave #(.DATA_W(DW), .TX_DEPTH(4), .RX_DEPTH(4)) dut (
        .pclk(pclk), .npreset(npreset), .psel(psel), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata),
        .pready(pready), .pslverr(pslverr), .transmit(transmit),
        .tx_data(tx_data), .tx_done(tx_done), .receive(receive),
        .rx_data(rx_data), .rx_done(rx_done), .rx_interrupt(rx_interrupt),
        .tx_interrupt(tx_interrupt)
    );

    always #5 pclk = ~pclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One APB transfer; optionally strobes receive during the ACCESS cycle.
    task automatic apb(input logic wr, input logic [3:0] a, input logic [DW-1:0] wd,
                       input logic rx_in_acc, input logic [DW-1:0] rx_w);
        rd = '0; err = 1'b0; lat = 0;
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd; lat = 1;
        @(posedge pclk); #1;
        penable = 1'b1; lat = 2;
        for (int i = 0; i < 8; i++) begin
            @(posedge pclk); #1;
            lat++;
            if (pready) break;
        end
        if (!pready) chk("pready_timeout", {31'b0, pready}, 1);
        else begin
            rd = prdata; err = pslverr;
            if (rx_in_acc) begin receive = 1'b1; rx_data = rx_w; end
        end
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; receive = 1'b0;
    endtask

    task automatic rx_strobe(input logic [DW-1:0] w, input logic accepted);
        @(posedge pclk); #1;
        receive = 1'b1; rx_data = w;
        @(posedge pclk); #1;
        receive = 1'b0;
        chk("rx_done_pulse", {31'b0, rx_done}, {31'b0, accepted});
        if (accepted) rx_q.push_back(w);
        @(posedge pclk); #1;
    endtask

    task automatic tx_take();
        for (int c = 0; c < 20; c++) begin
            if (transmit) break;
            @(posedge pclk); #1;
        end
        chk("tx_offer", {31'b0, transmit}, 1);
        exp_w = tx_q.pop_front();
        chk("tx_data", {24'b0, tx_data}, {24'b0, exp_w});
        tx_done = 1'b1;
        @(posedge pclk); #1;
        tx_done = 1'b0;
        chk("tx_gap", {31'b0, transmit}, 0);
    endtask

    initial begin
        #12;
        chk("rst_pready",  {31'b0, pready}, 0);
        chk("rst_prdata",  {24'b0, prdata}, 0);
        chk("rst_transmit", {31'b0, transmit}, 0);
        chk("rst_irqs",    {30'b0, rx_interrupt, tx_interrupt}, 0);
        @(posedge pclk); #1 npreset = 1'b1;

        // Reset status read with latency check
        apb(1'b0, 4'h4, 0, 1'b0, 0);
        chk("status_reset", {24'b0, rd}, 32'h05);
        chk("status_err", {31'b0, err}, 0);
        chk("pready_latency", lat, 3);
        chk("pready_one_cycle", {31'b0, pready}, 0);

        // Single TX word
        apb(1'b1, 4'h0, 8'hA5, 1'b0, 0);
        if (!err) tx_q.push_back(8'hA5);
        chk("tx_not_yet", {31'b0, transmit}, 0);
        @(posedge pclk); #1;
        chk("tx_two_after", {31'b0, transmit}, 1);
        tx_take();
        apb(1'b0, 4'h4, 0, 1'b0, 0);
        chk("status_tx_drained", {24'b0, rd}, 32'h05);

        // Stray tx_done while idle has no effect
        tx_done = 1'b1; @(posedge pclk); #1; tx_done = 1'b0;
        apb(1'b0, 4'h4, 0, 1'b0, 0);
        chk("stray_tx_done", {24'b0, rd}, 32'h05);

        // Fill TX: fifth write overflows
        for (int i = 0; i < 5; i++) begin
            apb(1'b1, 4'h0, 8'h11 + 8'(i), 1'b0, 0);
            chk("tx_fill_err", {31'b0, err}, (i == 4) ? 1 : 0);
            if (!err) tx_q.push_back(8'h11 + 8'(i));
        end
        apb(1'b0, 4'h4, 0, 1'b0, 0);
        chk("status_tx_full", {24'b0, rd}, 32'h09);
        for (int i = 0; i < 4; i++) tx_take();
        repeat (3) @(posedge pclk);
        #1 chk("tx_quiet", {31'b0, transmit}, 0);

        // RX overrun
        for (int i = 0; i < 5; i++) rx_strobe(8'h21 + 8'(i), i < 4);
        apb(1'b0, 4'h4, 0, 1'b0, 0);
        chk("status_rx_overrun", {24'b0, rd}, 32'h16);
        for (int i = 0; i < 4; i++) begin
            apb(1'b0, 4'h0, 0, 1'b0, 0);
            exp_w = rx_q.pop_front();
            chk("rx_read", {24'b0, rd}, {24'b0, exp_w});
            chk("rx_read_err", {31'b0, err}, 0);
        end
        apb(1'b0, 4'h0, 0, 1'b0, 0);
        chk("rx_empty_err", {31'b0, err}, 1);
        chk("rx_empty_data", {24'b0, rd}, 0);
        apb(1'b0, 4'h4, 0, 1'b0, 0);
        chk("status_overrun_only", {24'b0, rd}, 32'h15);
        apb(1'b1, 4'hC, 8'h10, 1'b0, 0);
        chk("clr_err", {31'b0, err}, 0);
        apb(1'b0, 4'hC, 0, 1'b0, 0);
        chk("clr_read_err", {31'b0, err}, 1);
        apb(1'b1, 4'h4, 8'hFF, 1'b0, 0);
        chk("status_write_err", {31'b0, err}, 1);
        apb(1'b0, 4'h4, 0, 1'b0, 0);
        chk("status_cleared", {24'b0, rd}, 32'h05);

        // RX full: pop and receive in the same cycle
        for (int i = 0; i < 4; i++) rx_strobe(8'h31 + 8'(i), 1'b1);
        apb(1'b0, 4'h0, 0, 1'b1, 8'h35);
        exp_w = rx_q.pop_front();
        chk("rx_simul_read", {24'b0, rd}, {24'b0, exp_w});
        chk("rx_simul_done", {31'b0, rx_done}, 1);
        if (rx_done) rx_q.push_back(8'h35);
        apb(1'b0, 4'h4, 0, 1'b0, 0);
        chk("status_simul", {24'b0, rd}, 32'h06);
        for (int i = 0; i < 4; i++) begin
            apb(1'b0, 4'h0, 0, 1'b0, 0);
            exp_w = rx_q.pop_front();
            chk("rx_drain", {24'b0, rd}, {24'b0, exp_w});
        end

        // Interrupts
        apb(1'b1, 4'h8, 8'h01, 1'b0, 0);
        apb(1'b0, 4'h8, 0, 1'b0, 0);
        chk("irq_en_read", {24'b0, rd}, 32'h01);
        chk("rx_irq_idle", {31'b0, rx_interrupt}, 0);
        rx_strobe(8'h3C, 1'b1);
        chk("rx_irq_set", {31'b0, rx_interrupt}, 1);
        chk("tx_irq_masked", {31'b0, tx_interrupt}, 0);
        apb(1'b0, 4'h0, 0, 1'b0, 0);
        exp_w = rx_q.pop_front();
        chk("irq_read", {24'b0, rd}, {24'b0, exp_w});
        @(posedge pclk); #1;
        chk("rx_irq_clear", {31'b0, rx_interrupt}, 0);
        apb(1'b1, 4'h8, 8'h03, 1'b0, 0);
        @(posedge pclk); #1;
        chk("tx_irq_set", {31'b0, tx_interrupt}, 1);

        // Reset during ACCESS with TX busy
        apb(1'b1, 4'h0, 8'h77, 1'b0, 0);
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 4'h0; pwdata = 8'h88;
        @(posedge pclk); #1 penable = 1'b1;
        @(posedge pclk); #1;
        chk("pre_rst_pready", {31'b0, pready}, 1);
        chk("pre_rst_transmit", {31'b0, transmit}, 1);
        npreset = 1'b0; #1;
        chk("rst_abort_pready", {31'b0, pready}, 0);
        chk("rst_abort_transmit", {31'b0, transmit}, 0);
        chk("rst_abort_tx_data", {24'b0, tx_data}, 0);
        chk("rst_abort_irq", {31'b0, tx_interrupt}, 0);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        @(posedge pclk); #1 npreset = 1'b1;
        apb(1'b0, 4'h4, 0, 1'b0, 0);
        chk("status_after_rst", {24'b0, rd}, 32'h05);
        chk("latency_after_rst", lat, 3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/apb_txrx_slave.md
APB_TXRX_SLAVE -- requirements
Module: apb_txrx_slave

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, giving the data width of the APB, TX and RX paths.
REQ-002 The block SHALL have parameter TX_DEPTH, default 4, giving the TX FIFO entries; it is a power of 2 and at least 2.
REQ-003 The block SHALL have parameter RX_DEPTH, default 4, giving the RX FIFO entries; it is a power of 2 and at least 2.
REQ-004 The block SHALL have these ports (name, direction, width, meaning):
- pclk  in  1  sole clock; all logic on posedge.
- npreset  in  1  asynchronous, active-low reset.
- psel, penable, pwrite  in  1 each  APB controls.
- paddr  in  4  byte address; bits [3:2] select the register.
- pwdata  in  DATA_W  APB write data.
- prdata  out  DATA_W  APB read data.
- pready  out  1  transfer complete.
- pslverr  out  1  transfer error.
- transmit  out  1  TX word offered to the Transmit block.
- tx_data  out  DATA_W  TX FIFO head.
- tx_done  in  1  one-cycle pulse; Transmit block consumed tx_data.
- receive  in  1  one-cycle strobe; rx_data valid.
- rx_data  in  DATA_W  word from the Receive block.
- rx_done  out  1  one-cycle acknowledge of an accepted receive.
- rx_interrupt  out  1  RX interrupt to the CPU.
- tx_interrupt  out  1  TX interrupt to the CPU.

Function
REQ-005 The register map SHALL be:
- 0x0 DATA: a write pushes the TX FIFO; a read pops the RX FIFO.
- 0x4 STATUS (RO): {overrun, tx_full, tx_empty, rx_full, rx_empty} in bits [4:0].
- 0x8 IRQ_EN (RW): bit0 enables RX, bit1 enables TX.
- 0xC CLR (WO): writing bit4=1 clears overrun.
REQ-006 The APB FSM SHALL have states IDLE, SETUP and ACCESS:
- IDLE goes to SETUP on psel & !penable.
- SETUP goes to ACCESS on psel & penable.
- ACCESS asserts pready for exactly one cycle, then returns to IDLE; one wait state per transfer.
REQ-007 If psel drops in SETUP, the FSM SHALL return to IDLE with no side effect.
REQ-008 Register side effects (push, pop, IRQ_EN/CLR update) SHALL occur only in the ACCESS cycle with pready=1, exactly once per transfer.
REQ-009 prdata SHALL be registered, valid in the ACCESS cycle, and 0 otherwise; unused STATUS/IRQ_EN bits read 0.
REQ-010 pslverr SHALL assert with pready, with no state change, on any of:
- DATA write while TX is full;
- DATA read while RX is empty (prdata=0);
- write to STATUS;
- read of CLR.
REQ-011 The TX path SHALL have states TX_IDLE and TX_BUSY:
- In TX_IDLE with the FIFO non-empty, it enters TX_BUSY next cycle, asserting transmit with tx_data = head, both held stable.
- On tx_done in TX_BUSY, it pops the head and deasserts transmit for at least one cycle before offering the next word.
REQ-012 tx_done outside TX_BUSY SHALL be ignored.
REQ-013 On receive=1, if RX is not full, the block SHALL push rx_data and pulse rx_done the next cycle; if RX is full, it SHALL drop the word, set overrun (sticky) and give no rx_done.
REQ-014 On a simultaneous push and pop of the same FIFO:
- non-empty and non-full: both SHALL occur and the count is unchanged;
- RX full with APB pop and receive in the same cycle: the pop SHALL free space and the push SHALL succeed, with no overrun;
- TX empty: the pop cannot happen, and the push SHALL succeed.
REQ-015 The FIFOs SHALL use pointers of log2(DEPTH) bits plus a wrap bit, so full = equal index with differing wrap bit and empty = equal pointers; wrap-around is modulo DEPTH.
REQ-016 The interrupt outputs SHALL be registered:
- rx_interrupt = IRQ_EN[0] & (!rx_empty | overrun);
- tx_interrupt = IRQ_EN[1] & tx_empty.
REQ-017 FIFO storage SHALL not be reset; only pointers, flags and outputs are reset.

Reset
REQ-018 While npreset=0, the block SHALL hold these values asynchronously:
- FSMs in IDLE and TX_IDLE;
- pointers 0, so both FIFOs are empty;
- overrun=0, IRQ_EN=0;
- pready, pslverr, prdata, transmit, tx_data, rx_done, rx_interrupt and tx_interrupt all 0.
REQ-019 A reset mid-transfer or mid-TX SHALL abort the operation and discard FIFO contents; after release, the first APB transfer behaves as in REQ-006.

Verification
REQ-020 Reset, then read STATUS -> prdata=0x05 (tx_empty, rx_empty), pslverr=0, pready in the 3rd cycle after psel rises.
REQ-021 Write DATA 0xA5 -> transmit=1, tx_data=0xA5 two cycles after pready; pulse tx_done -> transmit=0 and STATUS tx_empty=1.
REQ-022 Five DATA writes with tx_done held 0 and TX_DEPTH=4 -> the 5th write returns pslverr=1, and the FIFO holds the first four words, sent in order.
REQ-023 Five receive strobes with RX_DEPTH=4 -> four rx_done pulses, overrun=1; reads return words 1-4, a 5th read gives pslverr=1 with prdata=0; CLR write clears overrun.
REQ-024 IRQ_EN=0x1, then one receive with 0x3C -> rx_interrupt=1; read DATA -> prdata=0x3C and rx_interrupt=0 the next cycle.
REQ-025 Assert npreset=0 during an ACCESS cycle with TX non-empty -> pready, transmit=0 immediately and STATUS=0x05 after release.
